// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register with ALU-control decode and
// per-operand forwarding, compiled in only when ID_EX_FORWARD_EN is defined.
module id_ex_fwd #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] raw,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] val
);
`ifdef ID_EX_FORWARD_EN
    logic exmem_hit, memwb_hit;

    // r0 is hardwired zero, so a pending write to it must never be forwarded
    assign exmem_hit = exmem_regwrite && (exmem_rd == addr) && (addr != '0);
    assign memwb_hit = memwb_regwrite && (memwb_rd == addr) && (addr != '0);

    always_comb begin
        val = raw;
        if (exmem_hit)
            val = exmem_result;
        else if (memwb_hit)
            val = memwb_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{addr, exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result};
    assign val = raw;
`endif
endmodule

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic              regwrite,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_regwrite
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] rt;
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } ex_entry_t;

    logic [NUM_OPS-1:0][REG_AW-1:0] op_addr;
    logic [NUM_OPS-1:0][DATA_W-1:0] op_raw;
    logic [NUM_OPS-1:0][DATA_W-1:0] op_fwd;
    logic [3:0]                     op_dec;
    logic                           vld_q;
    logic                           capture;
    ex_entry_t                      ent_q;
    ex_entry_t                      ent_d;

    // operand 0 is rs, operand 1 is rt
    assign op_addr = {rt_addr, rs_addr};
    assign op_raw  = {rt_data, rs_data};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        id_ex_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
            .addr          (op_addr[g]),
            .raw           (op_raw[g]),
            .exmem_regwrite(exmem_regwrite),
            .exmem_rd      (exmem_rd),
            .exmem_result  (exmem_result),
            .memwb_regwrite(memwb_regwrite),
            .memwb_rd      (memwb_rd),
            .memwb_result  (memwb_result),
            .val           (op_fwd[g])
        );
    end

    always_comb begin
        op_dec = 4'b1111;
        case (aluop)
            2'b00: op_dec = 4'b0010;
            2'b01: op_dec = 4'b0110;
            2'b11: op_dec = 4'b0001;
            default: begin
                case (funct)
                    6'b100000: op_dec = 4'b0010;
                    6'b100010: op_dec = 4'b0110;
                    6'b100100: op_dec = 4'b0000;
                    6'b100101: op_dec = 4'b0001;
                    6'b101010: op_dec = 4'b0111;
                    6'b100111: op_dec = 4'b1100;
                    6'b000000: op_dec = 4'b1101;
                    default:   op_dec = 4'b1111;
                endcase
            end
        endcase
    end

    always_comb begin
        ent_d          = '0;
        ent_d.a        = op_fwd[0];
        ent_d.b        = alusrc ? imm : op_fwd[1];
        ent_d.rt       = op_fwd[1];
        ent_d.op       = op_dec;
        ent_d.rd       = rd_addr;
        ent_d.regwrite = regwrite;
    end

    assign in_ready = !stall && (!vld_q || out_ready);
    assign capture  = in_valid && in_ready;

    // flush beats stall beats capture; an unaccepted entry simply holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ent_q <= '0;
        end else if (flush) begin
            vld_q          <= 1'b0;
            ent_q.regwrite <= 1'b0;
        end else if (stall) begin
            vld_q <= vld_q;
        end else if (capture) begin
            vld_q <= 1'b1;
            ent_q <= ent_d;
        end else if (out_ready) begin
            vld_q          <= 1'b0;
            ent_q.regwrite <= 1'b0;
        end
    end

    assign out_valid    = vld_q;
    assign alu_a        = ent_q.a;
    assign alu_b        = ent_q.b;
    assign alu_op       = ent_q.op;
    assign out_rt_data  = ent_q.rt;
    assign out_rd       = ent_q.rd;
    assign out_regwrite = ent_q.regwrite;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; forwarding expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        regwrite;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, flush;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, out_rt_data;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd;
    logic        out_regwrite;

    int tests = 0;
    int fails = 0;

    logic [5:0] fn_tab [8];
    logic [3:0] op_tab [8];

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alusrc(alusrc), .aluop(aluop), .funct(funct), .regwrite(regwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rt_data(out_rt_data),
        .out_rd(out_rd), .out_regwrite(out_regwrite)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fn_tab[0] = 6'b100000; op_tab[0] = 4'b0010;
        fn_tab[1] = 6'b100010; op_tab[1] = 4'b0110;
        fn_tab[2] = 6'b100100; op_tab[2] = 4'b0000;
        fn_tab[3] = 6'b100101; op_tab[3] = 4'b0001;
        fn_tab[4] = 6'b101010; op_tab[4] = 4'b0111;
        fn_tab[5] = 6'b100111; op_tab[5] = 4'b1100;
        fn_tab[6] = 6'b000000; op_tab[6] = 4'b1101;
        fn_tab[7] = 6'b001000; op_tab[7] = 4'b1111;

        // reset with a valid entry pending
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        rs_data = 32'd5; rt_data = 32'd3; imm = 32'd0;
        rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd7;
        alusrc = 1'b0; aluop = 2'b10; funct = 6'b100000; regwrite = 1'b1;
        exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        step(); step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_regwrite", {31'd0, out_regwrite}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_rt_data", out_rt_data, 32'd0);
        check("rst_rd", {27'd0, out_rd}, 32'd0);

        // first capture after release
        rst_n = 1'b1;
        step();
        check("cap_valid", {31'd0, out_valid}, 32'd1);
        check("cap_alu_a", alu_a, 32'd5);
        check("cap_alu_b", alu_b, 32'd3);
        check("cap_alu_op", {28'd0, alu_op}, 32'h2);
        check("cap_rt_data", out_rt_data, 32'd3);
        check("cap_rd", {27'd0, out_rd}, 32'd7);
        check("cap_regwrite", {31'd0, out_regwrite}, 32'd1);

        // drain with nothing new
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_regwrite", {31'd0, out_regwrite}, 32'd0);

        // forwarding priority on rs
        in_valid = 1'b1; rs_addr = 5'd4; rs_data = 32'h11;
        exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
        step();
        check("fwd_exmem", alu_a, FWD ? 32'hAA : 32'h11);
        exmem_regwrite = 1'b0;
        step();
        check("fwd_memwb", alu_a, FWD ? 32'hBB : 32'h11);
        rs_addr = 5'd0; exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        step();
        check("fwd_r0_raw", alu_a, 32'h11);

        // rt forwarding reaches out_rt_data even with the immediate selected
        exmem_regwrite = 1'b0; memwb_rd = 5'd5; memwb_result = 32'hCC;
        rt_addr = 5'd5; rt_data = 32'h66; alusrc = 1'b1; imm = 32'h1234;
        step();
        check("fwd_rt_data", out_rt_data, FWD ? 32'hCC : 32'h66);
        check("imm_sel_b", alu_b, 32'h1234);
        alusrc = 1'b0;
        step();
        check("fwd_rt_b", alu_b, FWD ? 32'hCC : 32'h66);

        // backpressure: entry holds for 3 cycles, new one lands when released
        memwb_regwrite = 1'b0; rs_addr = 5'd1; rs_data = 32'h33;
        step();
        check("bp_pre_a", alu_a, 32'h33);
        out_ready = 1'b0; rs_data = 32'h22;
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_a", alu_a, 32'h33);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_new_a", alu_a, 32'h22);

        // flush with stall and in_valid in the same cycle
        flush = 1'b1; stall = 1'b1; rs_data = 32'h44;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_regwrite", {31'd0, out_regwrite}, 32'd0);
        check("flush_no_cap", alu_a, 32'h22);
        flush = 1'b0;
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("stall_hold", {31'd0, out_valid}, 32'd0);
        stall = 1'b0;
        step();
        check("post_stall_a", alu_a, 32'h44);

        // ALU-control decode sweep
        for (int i = 0; i < 8; i++) begin
            funct = fn_tab[i];
            step();
            check("dec_funct", {28'd0, alu_op}, {28'd0, op_tab[i]});
        end
        aluop = 2'b00; funct = 6'b100010;
        step();
        check("dec_aluop00", {28'd0, alu_op}, 32'h2);
        aluop = 2'b11;
        step();
        check("dec_aluop11", {28'd0, alu_op}, 32'h1);
        aluop = 2'b01; alusrc = 1'b1; imm = 32'hFFFFFFFF;
        step();
        check("dec_aluop01", {28'd0, alu_op}, 32'h6);
        check("dec_imm_b", alu_b, 32'hFFFFFFFF);

        // reset mid-operation clears asynchronously
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_b", alu_b, 32'd0);
        rst_n = 1'b1; rs_data = 32'h77;
        step();
        check("midrst_recap", alu_a, 32'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width.
REQ-002 SHALL have parameter REG_AW, default 5: register-address width.
REQ-003 SHALL have ports clk input 1 (system clock) and rst_n input 1 (reset); one clock, reset is asynchronous and active-low.
REQ-004 SHALL have in_valid input 1 (decode-side entry valid) and in_ready output 1 (stage can accept).
REQ-005 SHALL have rs_data, rt_data, imm inputs DATA_W each (register reads, sign-extended immediate).
REQ-006 SHALL have rs_addr, rt_addr, rd_addr inputs REG_AW each.
REQ-007 SHALL have alusrc input 1, aluop input 2, funct input 6, regwrite input 1.
REQ-008 SHALL have exmem_regwrite input 1, exmem_rd input REG_AW, exmem_result input DATA_W, plus memwb_regwrite, memwb_rd, memwb_result (same widths).
REQ-009 SHALL have stall input 1 (hold) and flush input 1 (kill held entry).
REQ-010 SHALL have out_valid output 1 and out_ready input 1 (ALU side).
REQ-011 SHALL have registered outputs alu_a DATA_W, alu_b DATA_W, alu_op 4, out_rt_data DATA_W, out_rd REG_AW, out_regwrite 1.

Function
REQ-012 SHALL be a single-entry register; capture occurs on clk rising edge when in_valid && in_ready.
REQ-013 SHALL drive in_ready = !stall && (!out_valid || out_ready), combinationally.
REQ-014 SHALL give 1-cycle latency: captured entry appears with out_valid=1 the next cycle.
REQ-015 SHALL clear out_valid when out_ready=1 and no new capture; hold all outputs unchanged while out_valid && !out_ready.
REQ-016 SHALL, on flush=1, clear out_valid and out_regwrite next edge and not capture that cycle, regardless of in_valid/stall; flush beats capture.
REQ-017 SHALL, on stall=1 without flush, hold all state; in_ready=0.
REQ-018 SHALL decode alu_op: aluop 00 -> 0010; 01 -> 0110; 11 -> 0001; 10 -> funct lookup.
REQ-019 SHALL map funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100, 000000->1101, any other ->1111.
REQ-020 SHALL set alu_b = imm when alusrc=1, else forwarded rt value; alu_a = forwarded rs value.
REQ-021 SHALL forward per operand at capture: EX/MEM match (regwrite && rd==addr && rd!=0) first, else MEM/WB match, else raw register data.
REQ-022 SHALL never forward for address 0; register 0 reads pass raw data.
REQ-023 SHALL drive out_rt_data = forwarded rt value independent of alusrc.
REQ-024 SHALL keep out_regwrite=0 whenever out_valid=0.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force out_valid=0, out_regwrite=0, alu_a=0, alu_b=0, alu_op=0000, out_rt_data=0, out_rd=0.
REQ-026 SHALL discard any held entry on reset mid-operation; first capture possible on first edge after rst_n deasserts.
REQ-027 SHALL present in_ready=1 during reset if stall=0.

Configuration
REQ-028 SHALL compile forwarding only when macro ID_EX_FORWARD_EN is defined.
REQ-029 SHALL, without ID_EX_FORWARD_EN, use raw rs_data/rt_data; forwarding ports remain present and are ignored.

Verification
REQ-030 Reset: rst_n=0 with in_valid=1 -> all outputs 0, out_valid=0; release, capture rs_data=5, rt_data=3, aluop=10, funct=100000 -> next cycle alu_a=5, alu_b=3, alu_op=0010.
REQ-031 Forward priority: rs_addr=4, exmem (1,4,0xAA), memwb (1,4,0xBB) -> alu_a=0xAA; exmem_regwrite=0 -> 0xBB; rs_addr=0 -> raw rs_data.
REQ-032 Backpressure: out_valid=1, out_ready=0, in_valid=1 -> in_ready=0, outputs held 3 cycles; out_ready=1 -> new entry accepted same edge.
REQ-033 Flush vs capture: flush=1, in_valid=1, stall=1 same cycle -> out_valid=0, out_regwrite=0 next cycle, no capture.
REQ-034 Decode sweep: aluop=10 all seven funct codes plus funct=001000 -> expected alu_op values, 001000 -> 1111; aluop=01, alusrc=1, imm=0xFFFFFFFF -> alu_op=0110, alu_b=0xFFFFFFFF.
REQ-035 Macro off: repeat REQ-031 stimulus without ID_EX_FORWARD_EN -> alu_a equals raw rs_data.
